// File: rtl/four_bit_seq_booth_multplr_if.sv
// Handshake and data bundle between a requester and the sequential Booth
// multiplier: request strobe, signed operands, status and product.
interface four_bit_seq_booth_multplr_if #(
    parameter int N = 4
) ();
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    // Requester side: drives operands and strobe, observes status/result.
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    // Multiplier side: samples operands and strobe, drives status/result.
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/four_bit_seq_booth_multplr.sv
// Sequential radix-2 Booth multiplier. Captures two signed N-bit operands on
// start (only in IDLE), runs one add/subtract + arithmetic shift per clock for
// N clocks, then pulses done for one cycle with the 2N-bit product held in a
// register until the next completion. The accumulator is N+1 bits wide so that
// subtracting the most negative multiplicand cannot overflow.
module four_bit_seq_booth_multplr #(
    parameter int N = 4
) (
    input  logic                           clk,
    input  logic                           clr,
    four_bit_seq_booth_multplr_if.slave    bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [N:0]      acc_q, acc_d;
    logic [N:0]      m_q, m_d;
    logic [N-1:0]    q_q, q_d;
    logic            q1_q, q1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  product_q, product_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [N:0]      acc_sum_s;
    logic [N:0]      acc_shift_s;
    logic [N-1:0]    q_shift_s;

    // Booth step: add/subtract the multiplicand, then arithmetic right shift.
    always_comb begin
        acc_sum_s = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   acc_sum_s = acc_q + m_q;
            2'b10:   acc_sum_s = acc_q - m_q;
            default: acc_sum_s = acc_q;
        endcase
        acc_shift_s = {acc_sum_s[N], acc_sum_s[N:1]};
        q_shift_s   = {acc_sum_s[0], q_q[N-1:1]};
    end

    // Next-state, datapath and output decode for the control FSM.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = {bus.a[N-1], bus.a};
                    q_d     = bus.b;
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_shift_s;
                q_d   = q_shift_s;
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    product_d = {acc_shift_s[N-1:0], q_shift_s};
                    state_d   = DONE;
                end else begin
                    state_d   = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are registered copies of the next state, so they line
        // up with the state they describe without any input-to-output path.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_four_bit_seq_booth_multplr.sv
// Scoreboard bench for the sequential Booth multiplier (N=4). Stimulus pushes
// the expected product when it issues a request; a negedge monitor pops and
// compares on every done pulse and checks the product is held otherwise.
module tb_four_bit_seq_booth_multplr;
    logic clk;
    logic clr;

    four_bit_seq_booth_multplr_if #(.N(4)) bus ();

    four_bit_seq_booth_multplr #(.N(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    logic [7:0] exp_q[$];
    logic [7:0] hold_r;
    int         pass_cnt;
    int         total_cnt;
    int         done_cnt;
    bit         mon_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Any edge with clr low clears the held product.
    always @(posedge clk) begin
        if (clr === 1'b0) hold_r = 8'h00;
    end

    // Monitor: pop and compare on done, otherwise the product must be held.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
                end else begin
                    hold_r = exp_q.pop_front();
                    chk("product", {24'd0, bus.product}, {24'd0, hold_r});
                end
            end else begin
                chk("product_hold", {24'd0, bus.product}, {24'd0, hold_r});
            end
        end
    end

    // One multiply with cycle-accurate busy/done checks; call at posedge+#1 in IDLE.
    task automatic mul(input logic [3:0] ai, input logic [3:0] bi, input logic [7:0] exp);
        bus.start = 1'b1;
        bus.a     = ai;
        bus.b     = bi;
        exp_q.push_back(exp);
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) bus.start = 1'b0;
            if (k == 1) begin
                bus.a = ~ai;
                bus.b = ~bi;
            end
            chk($sformatf("busy_e%0d", k), {31'd0, bus.busy}, {31'd0, (k <= 4)});
            chk($sformatf("done_e%0d", k), {31'd0, bus.done}, {31'd0, (k == 4)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        pass_cnt  = 0;
        total_cnt = 0;
        done_cnt  = 0;
        mon_en    = 1'b0;
        hold_r    = 8'h00;
        clr       = 1'b0;
        bus.start = 1'b0;
        bus.a     = 4'h0;
        bus.b     = 4'h0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_product", {24'd0, bus.product}, 32'h00);
        mon_en = 1'b1;
        clr    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_product", {24'd0, bus.product}, 32'h00);

        // Basic signed multiplies and the most negative square.
        mul(4'h3, 4'h5, 8'h0F);
        mul(4'hF, 4'h1, 8'hFF);
        mul(4'h7, 4'h8, 8'hC8);
        mul(4'h8, 4'h8, 8'h40);

        // Requests during RUN and DONE are dropped; operand changes are ignored.
        dc0       = done_cnt;
        bus.a     = 4'h2;
        bus.b     = 4'h3;
        bus.start = 1'b1;
        exp_q.push_back(8'h06);
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1; bus.a = 4'h7; bus.b = 4'h7; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; bus.start = 1'b1;
        chk("ign_done_e4", {31'd0, bus.done}, 32'd1);
        @(posedge clk); #1; bus.start = 1'b0;
        chk("ign_busy_e5", {31'd0, bus.busy}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("ign_busy_after", {31'd0, bus.busy}, 32'd0);
        chk("ign_done_count", done_cnt - dc0, 32'd1);

        // Reset mid-operation aborts silently and clears the product.
        mul(4'h3, 4'h5, 8'h0F);
        dc0       = done_cnt;
        bus.a     = 4'h5;
        bus.b     = 4'h5;
        bus.start = 1'b1;
        exp_q.push_back(8'h19);
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1; clr = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_product", {24'd0, bus.product}, 32'h00);
        clr = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc0, 32'd0);
        mul(4'h2, 4'h2, 8'h04);

        // Back-to-back with start held high: done every N+2 = 6 edges.
        bus.a     = 4'hD;
        bus.b     = 4'h2;
        bus.start = 1'b1;
        repeat (3) exp_q.push_back(8'hFA);
        for (int k = 0; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k == 12) bus.start = 1'b0;
            chk($sformatf("b2b_done_e%0d", k), {31'd0, bus.done},
                {31'd0, (k == 4 || k == 10 || k == 16)});
            chk($sformatf("b2b_busy_e%0d", k), {31'd0, bus.busy},
                {31'd0, !(k == 5 || k == 11 || k == 17)});
        end

        // Exhaustive sweep against a signed reference.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                int si;
                int sj;
                int p;
                si = (i >= 8) ? i - 16 : i;
                sj = (j >= 8) ? j - 16 : j;
                p  = si * sj;
                mul(4'(i), 4'(j), p[7:0]);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
